sort_stream_adapter: RTL

SORT_STREAM_ADAPTER -- requirements
Module: sort_stream_adapter

---
 rtl/sort_stream_adapter.sv | 119 +++++++++++
 1 files changed

// File: rtl/sort_stream_adapter.sv
// ---------------------------------------------------------------------------
// sort_stream_adapter: valid/ready stream <-> batch sorter bridge.
// Gathers ELEMENTS inputs, pulses the sorter, then streams the sorted batch.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sort_stream_adapter #(
  parameter int BITWIDTH = 8,
  parameter int ELEMENTS = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [BITWIDTH-1:0]          s_data_i,
  output logic                         sort_en_o,
  output logic [ELEMENTS*BITWIDTH-1:0] sort_data_o,
  input  logic                         sort_done_i,
  input  logic [ELEMENTS*BITWIDTH-1:0] sort_result_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [BITWIDTH-1:0]          m_data_o,
  output logic                         m_last_o,
  output logic                         busy_o
);

  localparam int CW = $clog2(ELEMENTS);
  localparam int W  = ELEMENTS * BITWIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(ELEMENTS - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] unload_cnt;
  logic [W-1:0]  sort_data;
  logic [W-1:0]  result;
  logic          done_q;
  logic          s_fire;
  logic          m_fire;
  logic          done_rise;

  assign s_fire    = s_valid_i & (state == LOAD);
  assign m_fire    = m_ready_i & (state == UNLOAD);
  assign done_rise = sort_done_i & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready_o = 1'b0;
    sort_en_o = 1'b0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    busy_o    = 1'b1;
    case (state)
      LOAD: begin
        s_ready_o = 1'b1;
        busy_o    = 1'b0;
        if (s_valid_i && (load_cnt == LAST_IDX)) state_nxt = START;
      end
      START: begin
        sort_en_o = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Only a fresh edge counts; a level left high from earlier is ignored.
        if (done_rise) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        m_valid_o = 1'b1;
        m_last_o  = (unload_cnt == LAST_IDX);
        if (m_ready_i && (unload_cnt == LAST_IDX)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt   <= '0;
      unload_cnt <= '0;
      sort_data  <= '0;
      result     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= sort_done_i;
      if (s_fire) begin
        sort_data[load_cnt*BITWIDTH +: BITWIDTH] <= s_data_i;
        load_cnt <= (load_cnt == LAST_IDX) ? '0 : load_cnt + 1'b1;
      end
      if ((state == WAIT) && done_rise) begin
        result <= sort_result_i;
      end
      if (m_fire) begin
        unload_cnt <= (unload_cnt == LAST_IDX) ? '0 : unload_cnt + 1'b1;
      end
    end
  end

  assign sort_data_o = sort_data;
  assign m_data_o    = result[unload_cnt*BITWIDTH +: BITWIDTH];

endmodule

`default_nettype wire
